// File: rtl/cabac_byte_feeder.sv
// Byte source for the CABAC bitsNeeded stage: strips emulation-prevention bytes
// from the raw slice stream, buffers the cleaned bytes and delivers one per request.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | idle or serving requests directly from a non-empty FIFO
// S_STALL | one request is pending on an empty FIFO; served on first byte
module cabac_byte_feeder #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             request_byte,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             stall,
  output logic             epb_removed,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] count;
  logic [1:0]       zero_cnt;
  logic             accept;
  logic             is_epb;
  logic             push;
  logic             pop;

  // in_ready deliberately ignores a same-cycle pop so the full flag has no
  // combinational path from request_byte.
  assign in_ready   = !rst && !init && (count < DEPTH_L);
  assign accept     = in_valid && in_ready;
  assign is_epb     = (zero_cnt == 2'd2) && (in_data == 8'h03);
  assign push       = accept && !is_epb;
  assign stall      = (state == S_STALL);
  assign fifo_level = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (init) begin
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (request_byte) begin
            if (count != '0) begin
              pop = 1'b1;
            end else begin
              state_nxt = S_STALL;
            end
          end
        end
        S_STALL: begin
          // A further request while stalled is a protocol error and is dropped.
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // push is already gated by in_ready, so init never writes the array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      zero_cnt    <= 2'd0;
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      epb_removed <= 1'b0;
    end else if (init) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      zero_cnt    <= 2'd0;
      byte_valid  <= 1'b0;
      epb_removed <= 1'b0;
    end else begin
      byte_valid  <= pop;
      epb_removed <= accept && is_epb;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        byte_out <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Zero run length saturates at 2 so that 00 00 00 03 still drops the 03.
      if (accept) begin
        if (is_epb) begin
          zero_cnt <= 2'd0;
        end else if (in_data == 8'h00) begin
          if (zero_cnt != 2'd2) begin
            zero_cnt <= zero_cnt + 1'b1;
          end
        end else begin
          zero_cnt <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// Directed bench for cabac_byte_feeder: delivery order, EPB removal, stall,
// full FIFO, pointer wrap, init flush and asynchronous reset.
module tb_cabac_byte_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       request_byte;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       stall;
  logic       epb_removed;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  cabac_byte_feeder #(.DEPTH(4), .LVL_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .request_byte (request_byte),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .stall        (stall),
    .epb_removed  (epb_removed),
    .fifo_level   (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    request_byte = 1'b1;
    tick();
    request_byte = 1'b0;
    chk({tag, "_valid"}, 32'(byte_valid), 32'd1);
    chk({tag, "_data"}, 32'(byte_out), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = 8'h00; request_byte = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'h00);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_epb", 32'(epb_removed), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // basic delivery
    push_byte(8'h12);
    chk("b_lvl1", 32'(fifo_level), 32'd1);
    push_byte(8'h34);
    chk("b_lvl2", 32'(fifo_level), 32'd2);
    pop_expect("b_pop12", 8'h12);
    chk("b_lvl_a", 32'(fifo_level), 32'd1);
    pop_expect("b_pop34", 8'h34);
    chk("b_lvl_b", 32'(fifo_level), 32'd0);
    tick();
    chk("b_valid_pulse", 32'(byte_valid), 32'd0);

    // 00 00 03 01
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h03);
    chk("e1_epb", 32'(epb_removed), 32'd1);
    chk("e1_lvl_drop", 32'(fifo_level), 32'd2);
    push_byte(8'h01);
    chk("e1_epb_pulse", 32'(epb_removed), 32'd0);
    chk("e1_lvl", 32'(fifo_level), 32'd3);
    pop_expect("e1_p0", 8'h00);
    pop_expect("e1_p1", 8'h00);
    pop_expect("e1_p2", 8'h01);

    // 00 00 00 03: saturated zero count still drops the 03
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    chk("e2_epb_none", 32'(epb_removed), 32'd0);
    push_byte(8'h03);
    chk("e2_epb", 32'(epb_removed), 32'd1);
    chk("e2_lvl", 32'(fifo_level), 32'd3);
    pop_expect("e2_p0", 8'h00);
    pop_expect("e2_p1", 8'h00);
    pop_expect("e2_p2", 8'h00);

    // 00 00 03 03: only the first 03 dropped
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h03);
    chk("e3_epb", 32'(epb_removed), 32'd1);
    push_byte(8'h03);
    chk("e3_epb2", 32'(epb_removed), 32'd0);
    chk("e3_lvl", 32'(fifo_level), 32'd3);
    pop_expect("e3_p0", 8'h00);
    pop_expect("e3_p1", 8'h00);
    pop_expect("e3_p2", 8'h03);

    // stall on empty, then late arrival; a request while stalled is ignored
    request_byte = 1'b1;
    tick();
    request_byte = 1'b0;
    chk("s_stall", 32'(stall), 32'd1);
    chk("s_valid0", 32'(byte_valid), 32'd0);
    request_byte = 1'b1;
    tick();
    request_byte = 1'b0;
    chk("s_stall2", 32'(stall), 32'd1);
    tick();
    chk("s_stall3", 32'(stall), 32'd1);
    push_byte(8'hAB);
    chk("s_stall_wr", 32'(stall), 32'd1);
    chk("s_valid_wr", 32'(byte_valid), 32'd0);
    tick();
    chk("s_valid", 32'(byte_valid), 32'd1);
    chk("s_data", 32'(byte_out), 32'hAB);
    chk("s_stall_off", 32'(stall), 32'd0);
    chk("s_lvl", 32'(fifo_level), 32'd0);
    tick();
    chk("s_no_second", 32'(byte_valid), 32'd0);
    chk("s_no_restall", 32'(stall), 32'd0);

    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      push_byte(8'hA0 + 8'(i));
    end
    chk("f_lvl4", 32'(fifo_level), 32'd4);
    chk("f_ready0", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    chk("f_lvl_hold", 32'(fifo_level), 32'd4);
    request_byte = 1'b1;
    tick();
    request_byte = 1'b0;
    in_valid = 1'b0;
    chk("f_pop_data", 32'(byte_out), 32'hA0);
    chk("f_lvl3", 32'(fifo_level), 32'd3);
    chk("f_ready1", 32'(in_ready), 32'd1);

    // simultaneous push/pop across pointer wrap
    q.delete();
    q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i); request_byte = 1'b1;
      q.push_back(8'hB0 + 8'(i));
      e = q.pop_front();
      tick();
      chk("w_valid", 32'(byte_valid), 32'd1);
      chk("w_data", 32'(byte_out), 32'(e));
      chk("w_lvl", 32'(fifo_level), 32'd3);
    end
    in_valid = 1'b0; request_byte = 1'b0;
    while (q.size() > 0) begin
      logic [7:0] e;
      e = q.pop_front();
      pop_expect("w_drain", e);
    end
    chk("w_empty", 32'(fifo_level), 32'd0);

    // init clears zero count; request and in_valid ignored during init
    push_byte(8'h00);
    push_byte(8'h00);
    init = 1'b1; in_valid = 1'b1; in_data = 8'h03; request_byte = 1'b1;
    #1;
    chk("i_ready0", 32'(in_ready), 32'd0);
    tick();
    init = 1'b0; in_valid = 1'b0; request_byte = 1'b0;
    chk("i_lvl0", 32'(fifo_level), 32'd0);
    chk("i_valid0", 32'(byte_valid), 32'd0);
    chk("i_held", 32'(byte_out), 32'hB7);
    chk("i_stall0", 32'(stall), 32'd0);
    push_byte(8'h03);
    chk("i_lvl1", 32'(fifo_level), 32'd1);
    chk("i_epb0", 32'(epb_removed), 32'd0);
    pop_expect("i_pop03", 8'h03);
    request_byte = 1'b1;
    tick();
    request_byte = 1'b0;
    chk("i_stall1", 32'(stall), 32'd1);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("i_stall_clr", 32'(stall), 32'd0);
    chk("i_held2", 32'(byte_out), 32'h03);

    // asynchronous reset mid-cycle while stalled
    request_byte = 1'b1;
    tick();
    request_byte = 1'b0;
    chk("r_stall_pre", 32'(stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_stall", 32'(stall), 32'd0);
    chk("r_lvl", 32'(fifo_level), 32'd0);
    chk("r_byte_out", 32'(byte_out), 32'h00);
    chk("r_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("r_ready1", 32'(in_ready), 32'd1);
    request_byte = 1'b1;
    tick();
    request_byte = 1'b0;
    chk("r_stall_new", 32'(stall), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
